// File: rtl/stopwatch_ctrl_if.sv
// Handshake bundle between the stopwatch controller, the debounced buttons and the BCD digit chain.
interface stopwatch_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start_stop;
    logic                    lap;
    logic                    clear;
    logic [NUM_DIGITS-1:0]   digit_done;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    cnt_clr_n;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    running;
    logic                    lap_active;
    logic                    overflow;

    modport master (
        output start_stop, lap, clear, digit_done, digits_in,
        input  digit_en, cnt_clr_n, disp, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, lap, clear, digit_done, digits_in,
        output digit_en, cnt_clr_n, disp, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button press detect, tick prescaler, digit-chain enables, clear pulse, lap freeze.
// Build option STOPWATCH_AUTO_STOP_EN: hold at maximum and pause on overflow, overflow sticky until clear.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 1000000,
    parameter int NUM_DIGITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    stopwatch_ctrl_if.slave sw
);
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t                  state;
    logic [2:0]              btn, btn_q, press_q;
    logic [PW-1:0]           presc;
    logic                    tick;
    logic                    running, lap_active, overflow, cnt_clr_n;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [NUM_DIGITS:0]     done_chain;
    logic                    all_done, wrap_hit, en_mask, start_ok;
    logic                    ps_start, ps_lap, ps_clr, clr_issue;

    assign btn = {sw.clear, sw.lap, sw.start_stop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q   <= '0;
            press_q <= '0;
        end else begin
            btn_q   <= btn;
            press_q <= btn & ~btn_q;
        end
    end

    // start_stop beats lap beats clear; a losing press is dropped even if the winner is ignored.
    assign ps_start  = press_q[0];
    assign ps_lap    = press_q[1] & ~press_q[0];
    assign ps_clr    = press_q[2] & ~press_q[1] & ~press_q[0];
    assign clr_issue = ps_clr & ((state == IDLE) | (state == PAUSE));

    assign done_chain[0] = 1'b1;
    assign all_done      = done_chain[NUM_DIGITS];
    assign wrap_hit      = tick & running & all_done;

`ifdef STOPWATCH_AUTO_STOP_EN
    assign en_mask  = ~all_done;
    assign start_ok = ~overflow;
`else
    assign en_mask  = 1'b1;
    assign start_ok = 1'b1;
`endif

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign done_chain[i+1] = done_chain[i] & sw.digit_done[i];
        assign sw.digit_en[i]  = tick & running & done_chain[i] & en_mask;
    end

    // Phase is kept across PAUSE so a resumed run finishes the partial tick interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (clr_issue) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (running) begin
            tick  <= (presc == PRESC_LAST);
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end else begin
            tick  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            cnt_clr_n  <= 1'b1;
            overflow   <= 1'b0;
            disp       <= '0;
        end else begin
            cnt_clr_n <= ~clr_issue;
            // The RUN->LAP edge still loads disp, which is the lap capture.
            if (state != LAP) disp <= sw.digits_in;
`ifdef STOPWATCH_AUTO_STOP_EN
            if (clr_issue)     overflow <= 1'b0;
            else if (wrap_hit) overflow <= 1'b1;
`else
            overflow <= wrap_hit;
`endif
            case (state)
                IDLE: begin
                    if (ps_start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (ps_start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (ps_lap) begin
                        state      <= LAP;
                        lap_active <= 1'b1;
                    end
                end
                LAP: begin
                    if (ps_start) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (ps_lap) begin
                        state      <= RUN;
                        lap_active <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (ps_start && start_ok) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (ps_clr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
`ifdef STOPWATCH_AUTO_STOP_EN
            if (wrap_hit) begin
                state      <= PAUSE;
                running    <= 1'b0;
                lap_active <= 1'b0;
            end
`endif
        end
    end

    assign sw.cnt_clr_n  = cnt_clr_n;
    assign sw.disp       = disp;
    assign sw.running    = running;
    assign sw.lap_active = lap_active;
    assign sw.overflow   = overflow;
endmodule
